pipe_ctrl: RTL

//  Pipeline sequencer for the 5-stage core: drives enable/bubble controls of the IF/DC and DC/EX

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl_perf.sv | 37 +++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, the bubble instruction and the control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        HALT
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic ifdc_en;
        logic ifdc_bubble;
        logic dcex_en;
        logic dcex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN  = '{pc_en: 1'b1, pc_sel: 1'b0, ifdc_en: 1'b1, ifdc_bubble: 1'b0,
                                    dcex_en: 1'b1, dcex_bubble: 1'b0};
    localparam ctrl_t CTRL_BOOT = '{pc_en: 1'b0, pc_sel: 1'b0, ifdc_en: 1'b1, ifdc_bubble: 1'b1,
                                    dcex_en: 1'b1, dcex_bubble: 1'b1};
    localparam ctrl_t CTRL_HOLD = '{pc_en: 1'b0, pc_sel: 1'b0, ifdc_en: 1'b0, ifdc_bubble: 1'b0,
                                    dcex_en: 1'b0, dcex_bubble: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath-facing bundle of the pipeline sequencer; master is the controller, slave the datapath.
interface pipe_ctrl_if;

    logic        imem_ready;
    logic        dc_load_use;
    logic        ex_busy;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        halt_req;
    logic        resume;

    logic        pc_en;
    logic        pc_sel;
    logic [31:0] redirect_pc;
    logic        ifdc_en;
    logic        ifdc_bubble;
    logic        dcex_en;
    logic        dcex_bubble;
    logic        halted;

    modport master (
        input  imem_ready, dc_load_use, ex_busy, ex_redirect, ex_target, halt_req, resume,
        output pc_en, pc_sel, redirect_pc, ifdc_en, ifdc_bubble, dcex_en, dcex_bubble, halted
    );

    modport slave (
        output imem_ready, dc_load_use, ex_busy, ex_redirect, ex_target, halt_req, resume,
        input  pc_en, pc_sel, redirect_pc, ifdc_en, ifdc_bubble, dcex_en, dcex_bubble, halted
    );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// Stall and redirect performance counters for pipe_ctrl; present only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Both counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_d = stall_q + CNT_W'(stall_i);
        flush_d = flush_q + CNT_W'(flush_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: one prioritized set of PC / IF-DC / DC-EX controls per cycle.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_LAT = 1
`ifdef PIPE_CTRL_PERF_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.master bus
`ifdef PIPE_CTRL_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt_o
    , output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam logic [2:0] SQZ_INIT = 3'(FETCH_LAT);

    state_e      state_q, state_d;
    logic [2:0]  sqz_q, sqz_d;
    logic [31:0] redir_q, redir_d;
    ctrl_t       ctrl;

    // Next state and controls; a redirect is honoured in RUN and also restarts an ongoing FLUSH.
    always_comb begin
        state_d = state_q;
        sqz_d   = sqz_q;
        redir_d = redir_q;
        ctrl    = CTRL_RUN;
        unique case (state_q)
            BOOT: begin
                ctrl    = CTRL_BOOT;
                state_d = RUN;
            end
            RUN: begin
                if (bus.halt_req) begin
                    ctrl    = CTRL_HOLD;
                    state_d = HALT;
                end else if (bus.ex_busy) begin
                    ctrl = CTRL_HOLD;
                end else if (bus.ex_redirect) begin
                    ctrl.pc_sel      = 1'b1;
                    ctrl.ifdc_bubble = 1'b1;
                    ctrl.dcex_bubble = 1'b1;
                    redir_d          = bus.ex_target;
                    if (FETCH_LAT != 0) begin
                        sqz_d   = SQZ_INIT;
                        state_d = FLUSH;
                    end
                end else if (bus.dc_load_use) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.ifdc_en     = 1'b0;
                    ctrl.dcex_bubble = 1'b1;
                end else if (!bus.imem_ready) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.ifdc_bubble = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.ex_redirect && !bus.ex_busy) begin
                    ctrl.pc_sel      = 1'b1;
                    ctrl.ifdc_bubble = 1'b1;
                    ctrl.dcex_bubble = 1'b1;
                    redir_d          = bus.ex_target;
                    sqz_d            = SQZ_INIT;
                end else begin
                    ctrl.pc_en       = bus.imem_ready;
                    ctrl.ifdc_bubble = 1'b1;
                    ctrl.dcex_en     = !bus.ex_busy;
                    if (bus.imem_ready) begin
                        sqz_d = sqz_q - 3'd1;
                        if (sqz_q == 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            HALT: begin
                ctrl = CTRL_HOLD;
                if (bus.resume && !bus.halt_req) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            sqz_q   <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            sqz_q   <= sqz_d;
            redir_q <= redir_d;
        end
    end

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.pc_sel      = ctrl.pc_sel;
    assign bus.ifdc_en     = ctrl.ifdc_en;
    assign bus.ifdc_bubble = ctrl.ifdc_bubble;
    assign bus.dcex_en     = ctrl.dcex_en;
    assign bus.dcex_bubble = ctrl.dcex_bubble;
    assign bus.redirect_pc = redir_q;
    assign bus.halted      = (state_q == HALT);

`ifdef PIPE_CTRL_PERF_EN
    // BOOT is the reset shadow rather than a pipeline stall, so only RUN/FLUSH cycles are counted.
    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (!ctrl.pc_en && (state_q == RUN || state_q == FLUSH)),
        .flush_i     (ctrl.pc_sel),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );
`endif

endmodule
